// File: rtl/scpu_run_ctrl.sv
// Run/step/stop sequencer for the scpu core: owns cpu_rst and the per-cycle cpu_en.
// Define SCPU_RUN_CTRL_BP2_EN to add a second breakpoint comparator and the bp_hit output.

module scpu_run_ctrl #(
   parameter int PC_WIDTH       = 32,
   parameter int CNT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int RST_CYCLES     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   input  logic                 bp_en,
   input  logic [PC_WIDTH-1:0]  bp_addr,
`ifdef SCPU_RUN_CTRL_BP2_EN
   input  logic                 bp2_en,
   input  logic [PC_WIDTH-1:0]  bp2_addr,
   output logic                 bp_hit,
`endif
   input  logic [PC_WIDTH-1:0]  cpu_pc,
   input  logic                 cpu_halt,
   output logic                 cpu_rst,
   output logic                 cpu_en,
   output logic [1:0]           state,
   output logic [2:0]           stop_reason,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam logic [RCW-1:0]       RST_RELOAD  = RCW'(RST_CYCLES);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_STOP  = 2'd3;

   localparam logic [2:0] RSN_NONE    = 3'd0;
   localparam logic [2:0] RSN_USER    = 3'd1;
   localparam logic [2:0] RSN_BREAK   = 3'd2;
   localparam logic [2:0] RSN_TIMEOUT = 3'd3;
   localparam logic [2:0] RSN_HALT    = 3'd4;
   localparam logic [2:0] RSN_STEP    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_CPURST = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
   logic [2:0]           stop_reason_q, stop_reason_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
   logic                 skip_bp_q, skip_bp_d;
   logic                 step_q, step_d;
`ifdef SCPU_RUN_CTRL_BP2_EN
   logic                 bp_hit_q, bp_hit_d;
   logic                 bp2_match;
`endif

   logic accept_ok, cmd_fire;
   logic op_reset, op_run, op_step, op_stop;
   logic bp1_match, brk_hit, to_hit, stop_now;

   assign accept_ok = !reset && (state_q != ST_CPURST);
   assign cmd_fire  = cmd_valid && accept_ok;
   assign op_reset  = cmd_fire && (cmd_op == OP_RESET);
   assign op_run    = cmd_fire && (cmd_op == OP_RUN);
   assign op_step   = cmd_fire && (cmd_op == OP_STEP);
   assign op_stop   = cmd_fire && (cmd_op == OP_STOP);

   assign bp1_match = bp_en && (cpu_pc == bp_addr);
`ifdef SCPU_RUN_CTRL_BP2_EN
   assign bp2_match = bp2_en && (cpu_pc == bp2_addr);
   assign brk_hit   = (bp1_match || bp2_match) && !skip_bp_q;
`else
   assign brk_hit   = bp1_match && !skip_bp_q;
`endif
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TIMEOUT_VAL);
   // Any stop cause suppresses the enable in the same cycle it is seen.
   assign stop_now  = cpu_halt || brk_hit || to_hit || op_stop || op_reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_CPURST;
         rst_cnt_q     <= RST_RELOAD;
         stop_reason_q <= RSN_NONE;
         done_q        <= 1'b0;
         cycle_count_q <= '0;
         skip_bp_q     <= 1'b0;
         step_q        <= 1'b0;
`ifdef SCPU_RUN_CTRL_BP2_EN
         bp_hit_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         stop_reason_q <= stop_reason_d;
         done_q        <= done_d;
         cycle_count_q <= cycle_count_d;
         skip_bp_q     <= skip_bp_d;
         step_q        <= step_d;
`ifdef SCPU_RUN_CTRL_BP2_EN
         bp_hit_q      <= bp_hit_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      stop_reason_d = stop_reason_q;
      done_d        = 1'b0;
      skip_bp_d     = skip_bp_q;
      step_d        = 1'b0;
      cycle_count_d = cycle_count_q;
`ifdef SCPU_RUN_CTRL_BP2_EN
      bp_hit_d      = bp_hit_q;
`endif
      if (cpu_en && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + 1'b1;

      unique case (state_q)
         ST_CPURST: begin
            if (rst_cnt_q <= RCW'(1)) state_d = ST_IDLE;
            else                      rst_cnt_d = rst_cnt_q - 1'b1;
         end
         ST_IDLE: begin
            if (op_reset) begin
               state_d = ST_CPURST;
            end else if (step_q) begin
               done_d        = 1'b1;
               state_d       = cpu_halt ? ST_HALTED : ST_IDLE;
               stop_reason_d = cpu_halt ? RSN_HALT : RSN_STEP;
            end else if (op_run) begin
               state_d       = ST_RUN;
               stop_reason_d = RSN_NONE;
               skip_bp_d     = 1'b1;
            end else if (op_step) begin
               step_d = 1'b1;
            end
         end
         ST_RUN: begin
            skip_bp_d = 1'b0;
            if (cpu_halt) begin
               state_d = ST_HALTED; stop_reason_d = RSN_HALT; done_d = 1'b1;
            end else if (brk_hit) begin
               state_d = ST_IDLE; stop_reason_d = RSN_BREAK; done_d = 1'b1;
`ifdef SCPU_RUN_CTRL_BP2_EN
               bp_hit_d = !bp1_match;
`endif
            end else if (to_hit) begin
               state_d = ST_IDLE; stop_reason_d = RSN_TIMEOUT; done_d = 1'b1;
            end else if (op_stop) begin
               state_d = ST_IDLE; stop_reason_d = RSN_USER; done_d = 1'b1;
            end else if (op_reset) begin
               state_d = ST_CPURST;
            end
         end
         ST_HALTED: begin
            if (op_reset) state_d = ST_CPURST;
         end
         default: state_d = ST_CPURST;
      endcase

      // Entering or sitting in CPU reset clears the count; entry reloads the hold counter.
      if (state_d == ST_CPURST) begin
         cycle_count_d = '0;
         if (state_q != ST_CPURST) begin
            rst_cnt_d     = RST_RELOAD;
            stop_reason_d = RSN_NONE;
         end
      end
   end

   always_comb begin
      cmd_ready   = accept_ok;
      cpu_rst     = reset || (state_q == ST_CPURST);
      cpu_en      = 1'b0;
      if (!reset) begin
         if (state_q == ST_RUN)       cpu_en = !stop_now;
         else if (state_q == ST_IDLE) cpu_en = step_q;
      end
      state       = state_q;
      stop_reason = stop_reason_q;
      done        = done_q;
      cycle_count = cycle_count_q;
`ifdef SCPU_RUN_CTRL_BP2_EN
      bp_hit      = bp_hit_q;
`endif
   end

endmodule
